// File: rtl/serial_mod_n.sv
// Bit-serial modulo-N checker: folds a framed serial number into its remainder mod DIVISOR,
// LSB-first or MSB-first, and pulses result_valid when a frame completes.
module serial_mod_n #(
  parameter int  DIVISOR   = 3,
  parameter bit  MSB_FIRST = 1'b0,
  parameter int  CNT_W     = 8,
  localparam int RW        = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data,
  input  logic             data_start,
  input  logic             data_finish,
  output logic             busy,
  output logic [RW-1:0]    remainder,
  output logic             divisible,
  output logic             result_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic             aborted
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [RW:0]   NX    = (RW + 1)'(DIVISOR);
  localparam logic [RW-1:0] W_ONE = RW'(1);
  localparam logic [RW-1:0] W_TWO = (DIVISOR == 2) ? RW'(0) : RW'(2);

  // Every intermediate is below 2N, so one conditional subtract brings it into [0, N).
  function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
    logic [RW:0] y;
    if (x >= NX) y = x - NX;
    else         y = x;
    return y[RW-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;

  logic             take_bit_s;
  logic [RW-1:0]    acc_nxt_s;
  logic [RW-1:0]    w_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next accumulator/weight/count for the bit sampled this cycle (seeded on a start).
  always_comb begin
    take_bit_s = data_start || (state_q == BUSY);
    acc_nxt_s  = acc_q;
    w_nxt_s    = w_q;
    cnt_nxt_s  = cnt_q;
    if (data_start) begin
      acc_nxt_s = RW'(data);
      w_nxt_s   = W_TWO;
      cnt_nxt_s = CNT_W'(1);
    end else begin
      if (MSB_FIRST) begin
        acc_nxt_s = reduce({acc_q, data});
        w_nxt_s   = w_q;
      end else begin
        acc_nxt_s = reduce({1'b0, acc_q} + (data ? {1'b0, w_q} : {(RW + 1){1'b0}}));
        w_nxt_s   = reduce({w_q, 1'b0});
      end
      if (cnt_q == {CNT_W{1'b1}}) cnt_nxt_s = cnt_q;
      else                        cnt_nxt_s = cnt_q + CNT_W'(1);
    end
  end

  // Frame FSM and result capture.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    bc_d    = bc_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    if (take_bit_s) begin
      acc_d = acc_nxt_s;
      w_d   = w_nxt_s;
      cnt_d = cnt_nxt_s;
      if (data_finish) begin
        rem_d   = acc_nxt_s;
        div_d   = (acc_nxt_s == RW'(0));
        bc_d    = cnt_nxt_s;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (data_start && !data_finish) state_d = BUSY;
        else                            state_d = IDLE;
      end
      BUSY: begin
        abort_d = data_start;
        if (data_finish) state_d = IDLE;
        else             state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= RW'(0);
      w_q     <= W_ONE;
      cnt_q   <= CNT_W'(0);
      rem_q   <= RW'(0);
      div_q   <= 1'b0;
      bc_q    <= CNT_W'(0);
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      bc_q    <= bc_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

  assign busy         = (state_q == BUSY);
  assign remainder    = rem_q;
  assign divisible    = div_q;
  assign result_valid = valid_q;
  assign bit_count    = bc_q;
  assign aborted      = abort_q;

endmodule

// File: tb/tb_serial_mod_n.sv
// Directed bench for serial_mod_n: three instances (N=3 LSB, N=5 MSB, N=7 LSB) share one
// stimulus stream and are checked every cycle against a frame-level model plus literal results.
module tb_serial_mod_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic data_start = 1'b0;
  logic data_finish = 1'b0;

  always #5 clk = ~clk;

  logic       b3, v3, d3, a3;
  logic [1:0] r3;
  logic [7:0] c3;
  logic       b5, v5, d5, a5;
  logic [2:0] r5;
  logic [7:0] c5;
  logic       b7, v7, d7, a7;
  logic [2:0] r7;
  logic [7:0] c7;

  serial_mod_n #(.DIVISOR(3), .MSB_FIRST(1'b0), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .data(data), .data_start(data_start), .data_finish(data_finish),
    .busy(b3), .remainder(r3), .divisible(d3), .result_valid(v3), .bit_count(c3), .aborted(a3));
  serial_mod_n #(.DIVISOR(5), .MSB_FIRST(1'b1), .CNT_W(8)) u5 (
    .clk(clk), .rst(rst), .data(data), .data_start(data_start), .data_finish(data_finish),
    .busy(b5), .remainder(r5), .divisible(d5), .result_valid(v5), .bit_count(c5), .aborted(a5));
  serial_mod_n #(.DIVISOR(7), .MSB_FIRST(1'b0), .CNT_W(8)) u7 (
    .clk(clk), .rst(rst), .data(data), .data_start(data_start), .data_finish(data_finish),
    .busy(b7), .remainder(r7), .divisible(d7), .result_valid(v7), .bit_count(c7), .aborted(a7));

  int total = 0;
  int bad   = 0;

  // Frame-level model: bits of the open frame and of the last completed frame.
  bit open_m = 1'b0;
  bit have_res = 1'b0;
  bit vld_m = 1'b0;
  bit ab_m = 1'b0;
  int cnt_m = 0;
  bit cur_q[$];
  bit last_q[$];

  int nval = 0;
  int nab  = 0;
  int rq3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Value of the last completed frame mod n; the MSB of the number is the first bit
  // in MSB-first order and the last bit in LSB-first order.
  function automatic int fold_rem(input int n, input bit msb);
    int r = 0;
    int sz = last_q.size();
    for (int i = 0; i < sz; i++)
      r = (r * 2 + int'(msb ? last_q[i] : last_q[sz - 1 - i])) % n;
    return r;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit f, input bit d);
    vld_m = 1'b0;
    ab_m  = 1'b0;
    if (r) begin
      open_m = 1'b0; have_res = 1'b0; cnt_m = 0;
      cur_q.delete(); last_q.delete();
    end else if (s || open_m) begin
      if (s) begin
        ab_m = open_m;
        cur_q.delete();
      end
      cur_q.push_back(d);
      open_m = !f;
      if (f) begin
        last_q = cur_q;
        have_res = 1'b1;
        vld_m = 1'b1;
        cnt_m = (cur_q.size() > 255) ? 255 : cur_q.size();
      end
    end
  endtask

  task automatic check_inst(input string nm, input int n, input bit msb, input logic b,
                            input logic v, input logic dv, input logic a, input logic [2:0] r,
                            input logic [7:0] c);
    int er = have_res ? fold_rem(n, msb) : 0;
    chk({nm, " busy"}, 32'(b), 32'(open_m));
    chk({nm, " result_valid"}, 32'(v), 32'(vld_m));
    chk({nm, " aborted"}, 32'(a), 32'(ab_m));
    chk({nm, " bit_count"}, 32'(c), 32'(cnt_m));
    chk({nm, " remainder"}, 32'(r), 32'(er));
    chk({nm, " divisible"}, 32'(dv), 32'(have_res && er == 0));
  endtask

  task automatic cyc(input bit r, input bit s, input bit f, input bit d);
    rst = r; data_start = s; data_finish = f; data = d;
    @(posedge clk);
    @(negedge clk);
    model_step(r, s, f, d);
    check_inst("n3", 3, 1'b0, b3, v3, d3, a3, {1'b0, r3}, c3);
    check_inst("n5", 5, 1'b1, b5, v5, d5, a5, r5, c5);
    check_inst("n7", 7, 1'b0, b7, v7, d7, a7, r7, c7);
    if (v3 === 1'b1) begin nval++; rq3.push_back(int'(r3)); end
    if (a3 === 1'b1) nab++;
  endtask

  task automatic frame(input int n, input logic [63:0] v, input bit msb);
    logic [63:0] vv = v;
    for (int i = 0; i < n; i++)
      cyc(1'b0, i == 0, i == n - 1, msb ? vv[n - 1 - i] : vv[i]);
  endtask

  task automatic frame_ones(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, i == 0, i == n - 1, 1'b1);
  endtask

  task automatic clr();
    nval = 0; nab = 0; rq3.delete();
  endtask

  function automatic int qat(input int i);
    return (rq3.size() > i) ? rq3[i] : -1;
  endfunction

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset rem", 32'(r3), 32'd0);
    chk("reset bit_count", 32'(c3), 32'd0);

    clr(); frame(8, 64'd129, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("129 pulses", 32'(nval), 32'd1);
    chk("129 rem", 32'(qat(0)), 32'd0);
    chk("129 divisible", 32'(d3), 32'd1);
    chk("129 bit_count", 32'(c3), 32'd8);

    clr(); frame(8, 64'd136, 1'b0); frame(8, 64'd128, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b pulses", 32'(nval), 32'd2);
    chk("136 rem", 32'(qat(0)), 32'd1);
    chk("128 rem", 32'(qat(1)), 32'd2);

    frame(8, 64'hFF, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("n5 0xFF rem", 32'(r5), 32'd0);
    frame(8, 64'h0D, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("n5 0x0D rem", 32'(r5), 32'd3);

    cyc(1'b0, 1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("n7 1bit rem", 32'(r7), 32'd1);
    chk("n7 1bit count", 32'(c7), 32'd1);

    frame_ones(40); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("40 ones rem", 32'(r3), 32'd0);
    chk("40 ones count", 32'(c3), 32'd40);
    frame_ones(300); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("300 saturate", 32'(c3), 32'd255);

    clr();
    cyc(1'b0, 1'b1, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b1);
    frame(4, 64'd5, 1'b0); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart aborts", 32'(nab), 32'd1);
    chk("restart pulses", 32'(nval), 32'd1);
    chk("restart rem", 32'(qat(0)), 32'd2);

    clr();
    cyc(1'b0, 1'b1, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s+f busy aborts", 32'(nab), 32'd1);
    chk("s+f busy pulses", 32'(nval), 32'd1);
    chk("s+f busy count", 32'(c3), 32'd1);

    frame(2, 64'd1, 1'b0);
    clr();
    cyc(1'b0, 1'b1, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b1); cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst mid pulses", 32'(nval + nab), 32'd0);
    chk("rst mid rem", 32'(r3), 32'd0);
    chk("rst mid count", 32'(c3), 32'd0);

    clr();
    cyc(1'b0, 1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle finish ignored", 32'(nval), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
